// File: rtl/cpu_host_loader_if.sv
// ---------------------------------------------------------------------------
// cpu_host_loader_if
// Purpose: bundles the loader's streaming handshakes and the cpu's two
//          external memory ports so they travel as one port.
// Signals:
//   in_valid/in_ready/in_data      load stream (host -> loader)
//   out_valid/out_ready/out_data   dump stream (loader -> host)
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext              imem port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2    dmem port
// Modports:
//   master - the loader side (drives strobes, in_ready, dump stream)
//   slave  - host link plus cpu memory side
// ---------------------------------------------------------------------------
interface cpu_host_loader_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic [31:0]       addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [31:0]       wdata_ext;
  logic [31:0]       rdata_ext;

  logic [31:0]       addr_ext_2;
  logic              wen_ext_2;
  logic              ren_ext_2;
  logic [31:0]       wdata_ext_2;
  logic [31:0]       rdata_ext_2;

  modport master (
    input  in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    output in_ready, out_valid, out_data,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    input  in_ready, out_valid, out_data,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_host_loader.sv
// ---------------------------------------------------------------------------
// cpu_host_loader
// Purpose: host-side initiator for the cpu's external memory ports. Streams a
//          program into instruction memory and initial data into data memory,
//          runs the cpu for a programmed number of cycles, then (optionally)
//          streams a window of data memory back to the host.
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   start         one-cycle pulse, honoured only in IDLE
//   imem_words    words to write into instruction memory (latched at start)
//   dmem_words    words to write into data memory (latched at start)
//   run_cycles    cycles to hold enable high (latched at start)
//   dump_words    data-memory words to read back from address 0
//   bus           cpu_host_loader_if.master: load/dump streams, memory ports
//   enable        cpu run enable
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse on return to IDLE after a sequence
// Configuration:
//   CPU_HOST_LOADER_DUMP_EN  defined   -> DUMP_RD/DUMP_OUT read-back phase
//                            undefined -> no dump; dump_words is ignored
// ---------------------------------------------------------------------------
module cpu_host_loader #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int RUN_W     = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      imem_words,
  input  logic [CNT_W-1:0]      dmem_words,
  input  logic [RUN_W-1:0]      run_cycles,
  input  logic [CNT_W-1:0]      dump_words,
  cpu_host_loader_if.master     bus,
  output logic                  enable,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN
`ifdef CPU_HOST_LOADER_DUMP_EN
    ,
    DUMP_RD,
    DUMP_OUT
`endif
  } state_t;

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t             state;
  logic [CNT_W-1:0]   imem_cnt;
  logic [CNT_W-1:0]   dmem_cnt;
  logic [RUN_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   idx;
  logic [RUN_W-1:0]   run_ctr;
  logic               done_q;

  logic [CNT_W-1:0]   idx_inc;
  logic [RUN_W-1:0]   run_inc;
  logic [31:0]        idx_addr;
  logic               load_i_hs;
  logic               load_d_hs;

  state_t             after_start;
  state_t             after_i;
  state_t             after_d;
  state_t             after_run;

`ifdef CPU_HOST_LOADER_DUMP_EN
  logic [CNT_W-1:0]   dump_cnt;
  logic [DATA_W-1:0]  out_data_q;
  logic               captured;
`endif

  // Chooses the next phase with a nonzero count, searching in sequence order
  // from the phase after 'stage' (0 = from IDLE, 1 = after LOAD_I,
  // 2 = after LOAD_D, 3 = after RUN). Falls back to IDLE when nothing is left.
  function automatic state_t pick_phase(
    input logic [2:0] stage,
    input logic       i_nz,
    input logic       d_nz,
    input logic       r_nz
`ifdef CPU_HOST_LOADER_DUMP_EN
    ,
    input logic       u_nz
`endif
  );
    state_t nxt;
    nxt = IDLE;
`ifdef CPU_HOST_LOADER_DUMP_EN
    if (stage < 3'd4 && u_nz) nxt = DUMP_RD;
`endif
    if (stage < 3'd3 && r_nz) nxt = RUN;
    if (stage < 3'd2 && d_nz) nxt = LOAD_D;
    if (stage < 3'd1 && i_nz) nxt = LOAD_I;
    return nxt;
  endfunction

  // From IDLE the raw inputs decide, since the counts are latched on the same edge.
  assign after_start = pick_phase(3'd0, |imem_words, |dmem_words, |run_cycles
`ifdef CPU_HOST_LOADER_DUMP_EN
    , |dump_words
`endif
  );
  assign after_i = pick_phase(3'd1, 1'b0, |dmem_cnt, |run_cnt
`ifdef CPU_HOST_LOADER_DUMP_EN
    , |dump_cnt
`endif
  );
  assign after_d = pick_phase(3'd2, 1'b0, 1'b0, |run_cnt
`ifdef CPU_HOST_LOADER_DUMP_EN
    , |dump_cnt
`endif
  );
  assign after_run = pick_phase(3'd3, 1'b0, 1'b0, 1'b0
`ifdef CPU_HOST_LOADER_DUMP_EN
    , |dump_cnt
`endif
  );

  assign idx_inc  = idx + CNT_W'(1);
  assign run_inc  = run_ctr + RUN_W'(1);
  assign idx_addr = 32'(idx) * STEP;

  // Writes fire in the handshake cycle itself; in_ready is a pure state decode,
  // so a handshake is simply in_valid while a load phase is active.
  assign load_i_hs = (state == LOAD_I) && bus.in_valid;
  assign load_d_hs = (state == LOAD_D) && bus.in_valid;

  assign bus.in_ready  = (state == LOAD_I) || (state == LOAD_D);

  assign bus.wen_ext   = load_i_hs;
  assign bus.ren_ext   = 1'b0;
  assign bus.addr_ext  = load_i_hs ? idx_addr : 32'd0;
  assign bus.wdata_ext = load_i_hs ? 32'(bus.in_data) : 32'd0;

  assign bus.wen_ext_2   = load_d_hs;
  assign bus.wdata_ext_2 = load_d_hs ? 32'(bus.in_data) : 32'd0;

  assign enable = (state == RUN);
  assign busy   = (state != IDLE);
  assign done   = done_q;

`ifdef CPU_HOST_LOADER_DUMP_EN
  assign bus.ren_ext_2  = (state == DUMP_RD);
  assign bus.addr_ext_2 = (load_d_hs || state == DUMP_RD) ? idx_addr : 32'd0;
  assign bus.out_valid  = (state == DUMP_OUT);
  // The read data arrives in the first DUMP_OUT cycle, so it is passed straight
  // through then and served from the capture register while the host stalls.
  assign bus.out_data   = (state != DUMP_OUT) ? '0 :
                          captured ? out_data_q : DATA_W'(bus.rdata_ext_2);
`else
  assign bus.ren_ext_2  = 1'b0;
  assign bus.addr_ext_2 = load_d_hs ? idx_addr : 32'd0;
  assign bus.out_valid  = 1'b0;
  assign bus.out_data   = '0;

  logic unused_dump;
  assign unused_dump = ^{dump_words, bus.out_ready, bus.rdata_ext_2};
`endif

  logic unused_rdata;
  assign unused_rdata = ^bus.rdata_ext;

  // Sequencer: one index register serves load and dump addressing and is
  // cleared on every phase entry; run_ctr counts enable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      imem_cnt <= '0;
      dmem_cnt <= '0;
      run_cnt  <= '0;
      idx      <= '0;
      run_ctr  <= '0;
      done_q   <= 1'b0;
`ifdef CPU_HOST_LOADER_DUMP_EN
      dump_cnt   <= '0;
      out_data_q <= '0;
      captured   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            imem_cnt <= imem_words;
            dmem_cnt <= dmem_words;
            run_cnt  <= run_cycles;
`ifdef CPU_HOST_LOADER_DUMP_EN
            dump_cnt <= dump_words;
`endif
            idx     <= '0;
            run_ctr <= '0;
            state   <= after_start;
            done_q  <= (after_start == IDLE);
          end
        end
        LOAD_I: begin
          if (bus.in_valid) begin
            if (idx_inc == imem_cnt) begin
              idx    <= '0;
              state  <= after_i;
              done_q <= (after_i == IDLE);
            end else begin
              idx <= idx_inc;
            end
          end
        end
        LOAD_D: begin
          if (bus.in_valid) begin
            if (idx_inc == dmem_cnt) begin
              idx    <= '0;
              state  <= after_d;
              done_q <= (after_d == IDLE);
            end else begin
              idx <= idx_inc;
            end
          end
        end
        RUN: begin
          if (run_inc == run_cnt) begin
            run_ctr <= '0;
            state   <= after_run;
            done_q  <= (after_run == IDLE);
          end else begin
            run_ctr <= run_inc;
          end
        end
`ifdef CPU_HOST_LOADER_DUMP_EN
        DUMP_RD: begin
          captured <= 1'b0;
          state    <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (!captured) begin
            out_data_q <= DATA_W'(bus.rdata_ext_2);
            captured   <= 1'b1;
          end
          if (bus.out_ready) begin
            if (idx_inc == dump_cnt) begin
              idx    <= '0;
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              idx   <= idx_inc;
              state <= DUMP_RD;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_host_loader
// Purpose: directed scoreboard bench for cpu_host_loader. Stimulus pushes
//          expected memory writes, dump words and done pulses (carrying the
//          expected enable-cycle count) into a queue; a monitor pops and
//          compares whenever the DUT shows one of those events.
// ---------------------------------------------------------------------------
module tb_cpu_host_loader;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int RUN_W  = 32;

  localparam int K_IMEM = 0;
  localparam int K_DMEM = 1;
  localparam int K_OUT  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] imem_words;
  logic [CNT_W-1:0] dmem_words;
  logic [RUN_W-1:0] run_cycles;
  logic [CNT_W-1:0] dump_words;
  logic             enable;
  logic             busy;
  logic             done;

  cpu_host_loader_if #(.DATA_W(DATA_W)) bus ();

  cpu_host_loader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .RUN_W(RUN_W), .ADDR_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words),
    .run_cycles(run_cycles), .dump_words(dump_words),
    .bus(bus), .enable(enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Data-memory model: synchronous write, read data one cycle after ren.
  logic [31:0] dmem [0:15];
  assign bus.rdata_ext = 32'd0;
  always @(posedge clk) begin
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[5:2]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[5:2]];
  end

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input int kind, input logic [31:0] addr,
                              input logic [31:0] data, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: actual=unexpected event addr=0x%0h data=0x%0h required=none",
               name, addr, data);
    end else begin
      e = exp_q.pop_front();
      check_output({name, "_kind"}, 32'(kind), 32'(e.kind));
      check_output({name, "_addr"}, addr, e.addr);
      check_output({name, "_data"}, data, e.data);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  int          en_count = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        en_count   = 0;
        stall_prev = 1'b0;
      end else begin
        if (enable) en_count++;
        if (bus.wen_ext)   expect_event(K_IMEM, bus.addr_ext,   bus.wdata_ext,   "imem_write");
        if (bus.wen_ext_2) expect_event(K_DMEM, bus.addr_ext_2, bus.wdata_ext_2, "dmem_write");
        if (stall_prev) begin
          check_output("out_valid_hold", 32'(bus.out_valid), 32'd1);
          check_output("out_data_hold", bus.out_data, stall_data);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        if (bus.out_valid && bus.out_ready)
          expect_event(K_OUT, 32'd0, bus.out_data, "dump_word");
        if (done) begin
          expect_event(K_DONE, 32'd0, 32'(en_count), "done_enable_cycles");
          check_output("busy_at_done", 32'(busy), 32'd0);
          en_count = 0;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] d,
                                input logic [RUN_W-1:0] r, input logic [CNT_W-1:0] u);
    @(posedge clk);
    #1;
    imem_words = i;
    dmem_words = d;
    run_cycles = r;
    dump_words = u;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  // Presents one word and holds it until accepted; caller is just past a rising edge.
  task automatic send_word(input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_enable"}, 32'(enable), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_output({tag, "_strobes"},
                 32'({bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2, bus.out_valid}), 32'd0);
    check_output({tag, "_addr_ext"}, bus.addr_ext, 32'd0);
    check_output({tag, "_addr_ext_2"}, bus.addr_ext_2, 32'd0);
    check_output({tag, "_wdata_ext"}, bus.wdata_ext, 32'd0);
    check_output({tag, "_out_data"}, bus.out_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    imem_words   = '0;
    dmem_words   = '0;
    run_cycles   = '0;
    dump_words   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    // Reset mid-LOAD_I, then a fresh load restarts from address 0.
    push_exp(K_IMEM, 32'd0, 32'h1);
    push_exp(K_IMEM, 32'd4, 32'h2);
    apply_stimulus(16'd4, 16'd0, 32'd0, 16'd0);
    send_word(32'h1);
    send_word(32'h2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_load_reset");
    check_output("reset_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    push_exp(K_IMEM, 32'd0, 32'h55);
    push_exp(K_IMEM, 32'd4, 32'h66);
    push_exp(K_DONE, 32'd0, 32'd0);
    apply_stimulus(16'd2, 16'd0, 32'd0, 16'd0);
    send_word(32'h55);
    send_word(32'h66);
    wait_drain();

    // Back-to-back load of both memories, checking start-to-ready latency.
    push_exp(K_IMEM, 32'd0, 32'h11);
    push_exp(K_IMEM, 32'd4, 32'h22);
    push_exp(K_IMEM, 32'd8, 32'h33);
    push_exp(K_DMEM, 32'd0, 32'hA);
    push_exp(K_DMEM, 32'd4, 32'hB);
    push_exp(K_DONE, 32'd0, 32'd0);
    apply_stimulus(16'd3, 16'd2, 32'd0, 16'd0);
    @(negedge clk);
    check_output("first_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_word(32'h11);
    send_word(32'h22);
    send_word(32'h33);
    send_word(32'hA);
    send_word(32'hB);
    wait_drain();

    // Stalled input: valid pattern 1,0,0,1 keeps addresses contiguous.
    push_exp(K_IMEM, 32'd0, 32'h77);
    push_exp(K_IMEM, 32'd4, 32'h88);
    push_exp(K_DONE, 32'd0, 32'd0);
    apply_stimulus(16'd2, 16'd0, 32'd0, 16'd0);
    send_word(32'h77);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_word(32'h88);
    wait_drain();

    // Run for 5 cycles; a second start during RUN must not change its length.
    push_exp(K_DONE, 32'd0, 32'd5);
    apply_stimulus(16'd0, 16'd0, 32'd5, 16'd0);
    apply_stimulus(16'd0, 16'd0, 32'd9, 16'd0);
    wait_drain();

    // All counts zero: done exactly one cycle after start.
    push_exp(K_DONE, 32'd0, 32'd0);
    apply_stimulus(16'd0, 16'd0, 32'd0, 16'd0);
    @(negedge clk);
    check_output("zero_done", 32'(done), 32'd1);
    wait_drain();

`ifdef CPU_HOST_LOADER_DUMP_EN
    // Dump two words with the host stalling the first for 3 cycles.
    push_exp(K_DMEM, 32'd0, 32'hDEAD);
    push_exp(K_DMEM, 32'd4, 32'hBEEF);
    push_exp(K_OUT, 32'd0, 32'hDEAD);
    push_exp(K_OUT, 32'd0, 32'hBEEF);
    push_exp(K_DONE, 32'd0, 32'd0);
    bus.out_ready = 1'b0;
    apply_stimulus(16'd0, 16'd2, 32'd0, 16'd2);
    send_word(32'hDEAD);
    send_word(32'hBEEF);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check_output("out_valid_seen", 32'(seen), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    bus.out_ready = 1'b0;
`else
    // Without the dump phase, a dump-only request completes immediately.
    bus.out_ready = 1'b1;
    push_exp(K_DONE, 32'd0, 32'd0);
    apply_stimulus(16'd0, 16'd0, 32'd0, 16'd3);
    @(negedge clk);
    check_output("dump_disabled_done", 32'(done), 32'd1);
    wait_drain();
    bus.out_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
